// File: rtl/result_packer_pkg.sv
// -----------------------------------------------------------------------------
// result_packer_pkg
// Shared MVM definitions for the result packer. It holds the default word and
// element widths, plus the derivations of ELEMS (lanes per output word) and
// LVLW (width of a FIFO occupancy count).
// -----------------------------------------------------------------------------
package result_packer_pkg;

    localparam int MVM_DATAW = 512;
    localparam int MVM_OPREC = 32;

    // Number of OPREC-bit lanes in one DATAW-bit word.
    function automatic int elems_of(input int dataw, input int oprec);
        return dataw / oprec;
    endfunction

    // Width of a count that must represent the values 0..depth.
    function automatic int lvlw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_packer_if.sv
// -----------------------------------------------------------------------------
// result_packer_if
// Bundles the packer's datapath-side input stream and its NoC-side output
// handshake.
//   i_valid/i_result/i_flush : serial result elements from the datapath
//   o_valid/o_ready/o_data   : FIFO head word, valid/ready handshake
//   o_level/o_overflow       : FIFO occupancy and sticky drop flag
// The master modport is the environment: it drives elements and o_ready.
// The slave modport is the packer.
// -----------------------------------------------------------------------------
interface result_packer_if #(
    parameter int DATAW      = 512,
    parameter int OPREC      = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVLW = $clog2(FIFO_DEPTH + 1);

    logic             i_valid;
    logic [OPREC-1:0] i_result;
    logic             i_flush;
    logic             o_valid;
    logic             o_ready;
    logic [DATAW-1:0] o_data;
    logic [LVLW-1:0]  o_level;
    logic             o_overflow;

    modport master (
        output i_valid, i_result, i_flush, o_ready,
        input  o_valid, o_data, o_level, o_overflow
    );

    modport slave (
        input  i_valid, i_result, i_flush, o_ready,
        output o_valid, o_data, o_level, o_overflow
    );

endinterface

// File: rtl/result_packer_fifo.sv
// -----------------------------------------------------------------------------
// packer_fifo
// Synchronous FIFO of WIDTH-bit words, DEPTH entries. DEPTH need not be a
// power of two, because the pointers wrap explicitly.
// The read data port shows the head word, or zero when the FIFO is empty.
// A write is honoured while the FIFO is full only if a read happens on the
// same edge. The caller gates wr_en accordingly.
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en/rd_data,
//        full, empty, level (0..DEPTH).
// -----------------------------------------------------------------------------
module packer_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4,
    parameter int LVLW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVLW-1:0]  level
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; an empty FIFO masks it on the read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign full    = (level == LVLW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/result_packer.sv
// -----------------------------------------------------------------------------
// result_packer
// Packs serial OPREC-bit results from the MVM datapath into DATAW-bit words.
// The words are buffered in a small FIFO and drained over a valid/ready
// handshake. The datapath cannot stall. When a word completes while the FIFO
// is full and no pop is pending, the word is dropped and o_overflow is set
// (sticky until rst).
// Ports: clk, rst (sync, active-high), bus (result_packer_if.slave):
//        i_valid/i_result/i_flush in, o_ready in,
//        o_valid/o_data/o_level/o_overflow out.
// Optional feature: define RESULT_PACKER_RELU_EN to clamp each negative
// element to zero before packing. The clamp adds no latency.
// -----------------------------------------------------------------------------
module result_packer
    import result_packer_pkg::*;
#(
    parameter int DATAW      = MVM_DATAW,
    parameter int OPREC      = MVM_OPREC,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    result_packer_if.slave bus
);
    localparam int ELEMS = elems_of(DATAW, OPREC);
    localparam int LVLW  = lvlw_of(FIFO_DEPTH);
    localparam int FILLW = $clog2(ELEMS);

    if ((DATAW % OPREC) != 0) begin : g_bad_width
        $error("result_packer: DATAW must be a multiple of OPREC");
    end
    if (ELEMS < 2 || FIFO_DEPTH < 2) begin : g_bad_size
        $error("result_packer: need at least 2 lanes and FIFO_DEPTH >= 2");
    end

    function automatic logic [OPREC-1:0] relu(input logic signed [OPREC-1:0] x);
`ifdef RESULT_PACKER_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    logic [FILLW-1:0] fill;
    logic [FILLW-1:0] fill_nxt;
    logic [DATAW-1:0] pack_reg;
    logic [DATAW-1:0] pack_nxt;
    logic [DATAW-1:0] merged;
    logic             overflow;
    logic             overflow_nxt;
    logic             push_req;
    logic             wr_en;
    logic             rd_en;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        merged = pack_reg;
        if (bus.i_valid) merged[fill*OPREC +: OPREC] = relu(bus.i_result);

        // A completing element and a flush in the same cycle still push
        // only one word. A flush with nothing packed and no new element
        // pushes nothing.
        push_req = (bus.i_valid && (fill == FILLW'(ELEMS - 1)))
                || (bus.i_flush && (bus.i_valid || (fill != '0)));

        // A pop on the same edge frees the slot, so a full FIFO can accept.
        rd_en = bus.o_ready && !fifo_empty;
        wr_en = push_req && (!fifo_full || rd_en);

        overflow_nxt = overflow || (push_req && !wr_en);

        // fill and pack_reg clear even on a drop, so the next word stays
        // aligned to lane 0 and its padding lanes read as zero.
        if (push_req) begin
            fill_nxt = '0;
            pack_nxt = '0;
        end else if (bus.i_valid) begin
            fill_nxt = fill + 1'b1;
            pack_nxt = merged;
        end else begin
            fill_nxt = fill;
            pack_nxt = pack_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill     <= '0;
            pack_reg <= '0;
            overflow <= 1'b0;
        end else begin
            fill     <= fill_nxt;
            pack_reg <= pack_nxt;
            overflow <= overflow_nxt;
        end
    end

    packer_fifo #(
        .WIDTH (DATAW),
        .DEPTH (FIFO_DEPTH),
        .LVLW  (LVLW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (merged),
        .rd_en   (rd_en),
        .rd_data (bus.o_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.o_level)
    );

    assign bus.o_valid    = !fifo_empty;
    assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_result_packer.sv
// -----------------------------------------------------------------------------
// tb_result_packer
// Directed bench for result_packer with DATAW=128, OPREC=32, FIFO_DEPTH=2.
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, so every check sees the state that the preceding edge produced.
// -----------------------------------------------------------------------------
module tb_result_packer;

    localparam int DATAW = 128;
    localparam int OPREC = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    result_packer_if #(.DATAW(DATAW), .OPREC(OPREC), .FIFO_DEPTH(DEPTH)) bus ();

    result_packer #(.DATAW(DATAW), .OPREC(OPREC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [OPREC-1:0] d, input logic f);
        bus.i_valid  = v;
        bus.i_result = d;
        bus.i_flush  = f;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic feed(input logic [OPREC-1:0] base, input int n);
        for (int i = 0; i < n; i++) step(1'b1, base + OPREC'(i), 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0);
    endtask

    logic [DATAW-1:0] relu_exp;

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_result = '0;
        bus.i_flush  = 1'b0;
        bus.o_ready  = 1'b1;

        // Reset state
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rst_valid", DATAW'(bus.o_valid), '0);
        chk("rst_data", bus.o_data, '0);
        chk("rst_level", DATAW'(bus.o_level), '0);
        chk("rst_ovf", DATAW'(bus.o_overflow), '0);

        // 1: four elements make one word, popped on the next edge
        feed(32'd1, 3);
        chk("t1_partial_valid", DATAW'(bus.o_valid), '0);
        step(1'b1, 32'd4, 1'b0);
        chk("t1_valid", DATAW'(bus.o_valid), 1);
        chk("t1_data", bus.o_data, 128'h00000004_00000003_00000002_00000001);
        chk("t1_level", DATAW'(bus.o_level), 1);
        idle();
        chk("t1_pop_level", DATAW'(bus.o_level), 0);
        chk("t1_pop_data", bus.o_data, '0);

        // 2: partial word via flush, then flush with nothing packed
        feed(32'd7, 2);
        step(1'b0, '0, 1'b1);
        chk("t2_data", bus.o_data, 128'h00000000_00000000_00000008_00000007);
        chk("t2_level", DATAW'(bus.o_level), 1);
        step(1'b0, '0, 1'b1);
        chk("t2_noop_level", DATAW'(bus.o_level), 0);
        chk("t2_noop_valid", DATAW'(bus.o_valid), 0);

        // 3: overflow with o_ready low, then drain in order
        bus.o_ready = 1'b0;
        feed(32'h11, 4);
        feed(32'h21, 4);
        chk("t3_level_full", DATAW'(bus.o_level), 2);
        chk("t3_ovf_before", DATAW'(bus.o_overflow), 0);
        feed(32'h31, 4);
        chk("t3_level", DATAW'(bus.o_level), 2);
        chk("t3_ovf", DATAW'(bus.o_overflow), 1);
        chk("t3_head1", bus.o_data, 128'h00000014_00000013_00000012_00000011);
        bus.o_ready = 1'b1;
        idle();
        chk("t3_head2", bus.o_data, 128'h00000024_00000023_00000022_00000021);
        chk("t3_level1", DATAW'(bus.o_level), 1);
        idle();
        chk("t3_empty", DATAW'(bus.o_level), 0);
        chk("t3_ovf_sticky", DATAW'(bus.o_overflow), 1);

        // 4: push and pop on the same edge while full
        rst = 1'b1;
        idle();
        rst = 1'b0;
        bus.o_ready = 1'b0;
        feed(32'h41, 4);
        feed(32'h51, 4);
        feed(32'h61, 3);
        bus.o_ready = 1'b1;
        step(1'b1, 32'h64, 1'b0);
        chk("t4_level", DATAW'(bus.o_level), 2);
        chk("t4_ovf", DATAW'(bus.o_overflow), 0);
        chk("t4_head", bus.o_data, 128'h00000054_00000053_00000052_00000051);
        idle();
        chk("t4_head3", bus.o_data, 128'h00000064_00000063_00000062_00000061);
        idle();
        chk("t4_empty", DATAW'(bus.o_level), 0);

        // 5: completing element with flush gives exactly one word
        feed(32'h71, 3);
        step(1'b1, 32'h74, 1'b1);
        chk("t5_data", bus.o_data, 128'h00000074_00000073_00000072_00000071);
        chk("t5_level", DATAW'(bus.o_level), 1);
        idle();
        chk("t5_single", DATAW'(bus.o_level), 0);
        //    rst mid-word discards the partial lanes
        feed(32'h81, 2);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("t5_rst_valid", DATAW'(bus.o_valid), 0);
        chk("t5_rst_level", DATAW'(bus.o_level), 0);
        feed(32'h91, 4);
        chk("t5_realign", bus.o_data, 128'h00000094_00000093_00000092_00000091);
        idle();

        // 6: optional ReLU on negative elements
        step(1'b1, -32'sd5, 1'b0);
        step(1'b1, 32'd6, 1'b0);
        step(1'b1, -32'sd1, 1'b0);
        step(1'b1, 32'd9, 1'b0);
`ifdef RESULT_PACKER_RELU_EN
        relu_exp = 128'h00000009_00000000_00000006_00000000;
`else
        relu_exp = 128'h00000009_FFFFFFFF_00000006_FFFFFFFB;
`endif
        chk("t6_relu", bus.o_data, relu_exp);
        idle();
        chk("t6_empty", DATAW'(bus.o_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
